// File: rtl/gpu_axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI-lite read master between NUM_REQ GPU read clients.
// A single read is outstanding at a time: accept request, issue AR, return R, repeat.
module gpu_axi_read_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_arvalid,
  output logic [NUM_REQ-1:0]        req_arready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_araddr,
  output logic [NUM_REQ-1:0]        req_rvalid,
  input  logic [NUM_REQ-1:0]        req_rready,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [1:0]                req_rresp,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  output logic [ADDR_W-1:0]         m_axi_araddr,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  input  logic [DATA_W-1:0]         m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  output logic                      busy,
  output logic [IdW-1:0]            grant_id
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e              state_q;
  logic                arvalid_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [IdW-1:0]      grant_q;
  logic [IdW-1:0]      last_q;

  logic                pick_valid;
  logic [IdW-1:0]      pick_id;
  logic [ADDR_W-1:0]   pick_addr;

  // Lowest requester above last_q wins; otherwise wrap to the lowest at or below it.
  // The second loop overrides the first, which gives the rotated priority order.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_addr  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_arvalid[i] && (i <= int'(last_q))) begin
        pick_valid = 1'b1;
        pick_id    = IdW'(i);
        pick_addr  = req_araddr[i*ADDR_W +: ADDR_W];
      end
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_arvalid[i] && (i > int'(last_q))) begin
        pick_valid = 1'b1;
        pick_id    = IdW'(i);
        pick_addr  = req_araddr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    req_arready  = '0;
    req_rvalid   = '0;
    m_axi_rready = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) req_arready[pick_id] = 1'b1;
      end
      StData: begin
        req_rvalid[grant_q] = m_axi_rvalid;
        m_axi_rready        = req_rready[grant_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      grant_q   <= '0;
      last_q    <= IdW'(NUM_REQ - 1);
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            araddr_q  <= pick_addr;
            grant_q   <= pick_id;
            last_q    <= pick_id;
            arvalid_q <= 1'b1;
            state_q   <= StAddr;
          end
        end
        StAddr: begin
          if (arvalid_q && m_axi_arready) begin
            arvalid_q <= 1'b0;
            state_q   <= StData;
          end
        end
        StData: begin
          if (m_axi_rvalid && m_axi_rready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign req_rdata     = m_axi_rdata;
  assign req_rresp     = m_axi_rresp;
  assign busy          = (state_q != StIdle);
  assign grant_id      = grant_q;

endmodule

// File: doc/gpu_axi_read_arbiter.md
Name: gpu_axi_read_arbiter

Overview:
- Shares the GPU's single AXI-lite read master port between several GPU read clients, for example the sprite pixel fetch stage and the colour-table resolve stage.
- Only one read is outstanding at any time. Arbitration between pending requesters is round-robin.
- Each requester sees a private AXI-lite-style AR/R channel pair. The arbiter sits between the GPU pipeline stages and the system interconnect.

Parameters:
- NUM_REQ, 2: number of requester ports (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: read data width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_arvalid  in  NUM_REQ  per-requester read-address valid.
- req_arready  out  NUM_REQ  per-requester read-address ready, combinational.
- req_araddr  in  NUM_REQ*ADDR_W  flattened addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_rvalid  out  NUM_REQ  per-requester read-data valid.
- req_rready  in  NUM_REQ  per-requester read-data ready.
- req_rdata  out  DATA_W  read data, broadcast to all requesters.
- req_rresp  out  2  read response, broadcast to all requesters.
- m_axi_arvalid  out  1  master AR valid, registered.
- m_axi_arready  in  1  master AR ready.
- m_axi_araddr  out  ADDR_W  master AR address, registered.
- m_axi_rvalid  in  1  master R valid.
- m_axi_rready  out  1  master R ready.
- m_axi_rdata  in  DATA_W  master R data.
- m_axi_rresp  in  2  master R response.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current or last granted requester.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, m_axi_arvalid=0, m_axi_araddr=0, grant_id=0.
  - last_grant=NUM_REQ-1, so requester 0 has top priority after reset.
  - All combinational outputs follow from state: req_arready=0 except pick in IDLE, req_rvalid=0, m_axi_rready=0, busy=0.
- States and transitions:
  - IDLE → ADDR: some req_arvalid is high.
  - ADDR → DATA: m_axi_arvalid && m_axi_arready.
  - DATA → IDLE: m_axi_rvalid && m_axi_rready.
- Pick (combinational, IDLE only):
  - Scan i = last_grant+1, last_grant+2, … modulo NUM_REQ.
  - The first i with req_arvalid[i]=1 wins.
  - req_arready[i]=1 only for that winner; all other requesters see 0.
- IDLE with a winner:
  - The request handshake completes in this cycle.
  - Register m_axi_araddr = req_araddr[pick], grant_id=pick, last_grant=pick.
  - Set m_axi_arvalid=1 and go to ADDR. m_axi_arvalid therefore rises the cycle after the request handshake.
- ADDR:
  - Hold m_axi_arvalid and m_axi_araddr stable until m_axi_arready.
  - On handshake: m_axi_arvalid=0, go to DATA.
  - All req_arready=0.
- DATA:
  - req_rvalid[grant_id] = m_axi_rvalid; all other req_rvalid bits = 0.
  - m_axi_rready = req_rready[grant_id].
  - req_rdata and req_rresp pass m_axi_rdata and m_axi_rresp through combinationally.
  - On the R handshake, go to IDLE.
- Throughput and latency:
  - Minimum 3 cycles per transaction (IDLE, ADDR, DATA) with zero-wait-state slave.
  - No back-to-back issue.
  - No request is accepted before the previous R handshake completes.
- Fairness:
  - Any requester holding arvalid is granted within NUM_REQ transactions.
  - Requesters must keep arvalid and araddr stable until req_arready (AXI rule). The arbiter does not latch deasserted requests.
- Simultaneous events:
  - A new req_arvalid arriving in the cycle of the R handshake is not seen until the following IDLE cycle.
  - Requests arriving during ADDR/DATA wait and do not affect the current grant.
- Error responses:
  - rresp is passed through unmodified.
  - SLVERR/DECERR does not change arbitration.
- Reset mid-operation:
  - Immediate return to IDLE with arvalid=0 and rready=0.
  - Any in-flight read is abandoned. The interconnect and the requesters share rst and must reset together.
- Width rules:
  - last_grant and grant_id are $clog2(NUM_REQ) bits.
  - Modulo wrap is explicit, so non-power-of-two NUM_REQ is supported.

Test Plan:
- Single request: after reset, req0 arvalid with addr 0x0000_1000.
  - Required: req_arready[0]=1 same cycle; m_axi_arvalid=1, araddr=0x1000 next cycle.
  - Slave returns rdata=0xDEADBEEF: req_rvalid[0]=1 and rdata matches; busy=0 after the R handshake.
- Contention: req0 and req1 hold arvalid continuously, each with 4 reads, zero-wait slave.
  - Required: grant order 0,1,0,1,0,1,0,1; each transaction 3 cycles; req_rvalid never goes to the non-granted port.
- Backpressure:
  - m_axi_arready low for 5 cycles: araddr and arvalid stay stable.
  - Then req_rready[1] low for 3 cycles while m_axi_rvalid=1: m_axi_rready=0 and state stays DATA until req_rready rises.
- Wrap and fairness, NUM_REQ=3:
  - Requests from 2 then 0 after last_grant=1: required grant 2 then 0.
  - Requester 1 added later is granted within 3 transactions.
- Error pass-through: slave returns rresp=2'b10 → req_rresp=2'b10 at the granted port; next request is arbitrated normally.
- Reset mid-op: assert rst=0 in DATA with m_axi_rvalid pending.
  - Required: asynchronously busy=0, m_axi_arvalid=0, m_axi_rready=0.
  - After release, req0 is granted first.
